// File: rtl/ioexp_fifo.sv
// 8243-style nibble I/O expander bridging the meter PROG/P2 bus to byte FIFOs on the UART side.
// Optional sticky error flags are built when IOEXP_ERR_EN is defined.
module ioexp_fifo #(
  parameter int unsigned TX_DEPTH    = 8,
  parameter int unsigned RX_DEPTH    = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] p2i,
  output logic [3:0] p2o,
  output logic       p2_oe,
  input  logic       prog_n,
  input  logic [7:0] tx_wdata,
  input  logic       tx_wvalid,
  output logic       tx_wready,
  output logic [7:0] rx_rdata,
  output logic       rx_rvalid,
  input  logic       rx_rready,
  output logic [1:0] err,
  input  logic       err_clr
);
  localparam int unsigned TxAw = $clog2(TX_DEPTH);
  localparam int unsigned RxAw = $clog2(RX_DEPTH);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  logic [SYNC_STAGES-1:0]      prog_sync_q;
  logic [SYNC_STAGES-1:0][3:0] p2_sync_q;
  logic                        ps_prev_q;
  logic                        ps, prog_fall, prog_rise;
  logic [3:0]                  ds;

  // Sync chain resets to "PROG low" so a strobe held through reset never looks like a fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prog_sync_q <= '0;
      p2_sync_q   <= '0;
      ps_prev_q   <= 1'b0;
    end else begin
      prog_sync_q <= {prog_sync_q[SYNC_STAGES-2:0], prog_n};
      p2_sync_q   <= {p2_sync_q[SYNC_STAGES-2:0], p2i};
      ps_prev_q   <= ps;
    end
  end

  assign ps        = prog_sync_q[SYNC_STAGES-1];
  assign ds        = p2_sync_q[SYNC_STAGES-1];
  assign prog_fall = ps_prev_q & ~ps;
  assign prog_rise = ~ps_prev_q & ps;

  state_e state_q, state_d;
  logic   latch, exec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (prog_fall) state_d = StActive;
      StActive: if (prog_rise) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    latch = (state_q == StIdle) && prog_fall;
    exec  = (state_q == StActive) && prog_rise;
  end

  logic [1:0] cmd_q, cmd_d, addr_q, addr_d, rd_addr;
  logic       rd_pend_q, rd_pend_d;
  logic [3:0] p2o_q, p2o_d, p7_q, p7_d, p7_prev_q, rx_lo_q, rx_lo_d, rx_hi_q, rx_hi_d;
  logic [3:0] p6, rd_val;
  logic [7:0] tx_head;

  logic [TxAw:0] tx_wptr_q, tx_rptr_q;
  logic [RxAw:0] rx_wptr_q, rx_rptr_q;
  logic [7:0]    tx_mem [TX_DEPTH];
  logic [7:0]    rx_mem [RX_DEPTH];
  logic          tx_empty, tx_full, rx_empty, rx_full;
  logic          tx_push, tx_pop, rx_push, rx_pop;
  logic          hs_pop, hs_push, tx_unf_set, rx_ovf_set;

  assign p6      = {rx_full, 1'b1, 1'b0, tx_empty};
  assign tx_head = tx_empty ? 8'h00 : tx_mem[tx_rptr_q[TxAw-1:0]];
  assign rd_addr = latch ? ds[1:0] : addr_q;

  always_comb begin
    rd_val = 4'h0;
    unique case (rd_addr)
      2'd0:    rd_val = tx_head[3:0];
      2'd1:    rd_val = tx_head[7:4];
      2'd2:    rd_val = p6;
      default: rd_val = 4'h0;
    endcase
  end

  always_comb begin
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    rd_pend_d = rd_pend_q;
    p2o_d     = p2o_q;
    p7_d      = p7_q;
    rx_lo_d   = rx_lo_q;
    rx_hi_d   = rx_hi_q;
    if (latch) begin
      cmd_d     = ds[3:2];
      addr_d    = ds[1:0];
      rd_pend_d = (ds[3:2] == 2'b00);
      if (ds[3:2] == 2'b00) p2o_d = rd_val;
    end else if (rd_pend_q) begin
      // Keep the driven nibble tracking the FIFO/status while the meter holds PROG low.
      p2o_d = rd_val;
    end
    if (exec) begin
      rd_pend_d = 1'b0;
      unique case (cmd_q)
        2'b01: begin
          unique case (addr_q)
            2'd0:    rx_lo_d = ds;
            2'd1:    rx_hi_d = ds;
            2'd3:    p7_d    = ds;
            default: ;
          endcase
        end
        2'b10:   if (addr_q == 2'd3) p7_d = p7_q | ds;
        2'b11:   if (addr_q == 2'd3) p7_d = p7_q & ds;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q     <= 2'b00;
      addr_q    <= 2'b00;
      rd_pend_q <= 1'b0;
      p2o_q     <= 4'h0;
      p7_q      <= 4'hF;
      p7_prev_q <= 4'hF;
      rx_lo_q   <= 4'h0;
      rx_hi_q   <= 4'h0;
    end else begin
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      rd_pend_q <= rd_pend_d;
      p2o_q     <= p2o_d;
      p7_q      <= p7_d;
      p7_prev_q <= p7_q;
      rx_lo_q   <= rx_lo_d;
      rx_hi_q   <= rx_hi_d;
    end
  end

  assign p2o   = p2o_q;
  assign p2_oe = rd_pend_q & ~prog_n;

  // p7_prev_q lags p7_q by one clk, so each falling handshake bit yields a single-clk strobe.
  assign hs_pop     = p7_prev_q[1] & ~p7_q[1];
  assign hs_push    = p7_prev_q[2] & ~p7_q[2];
  assign tx_pop     = hs_pop & ~tx_empty;
  assign tx_unf_set = hs_pop & tx_empty;
  assign rx_push    = hs_push & ~rx_full;
  assign rx_ovf_set = hs_push & rx_full;
  assign tx_push    = tx_wvalid & tx_wready;
  assign rx_pop     = rx_rvalid & rx_rready;

  assign tx_empty = (tx_wptr_q == tx_rptr_q);
  assign tx_full  = (tx_wptr_q[TxAw] != tx_rptr_q[TxAw]) &&
                    (tx_wptr_q[TxAw-1:0] == tx_rptr_q[TxAw-1:0]);
  assign rx_empty = (rx_wptr_q == rx_rptr_q);
  assign rx_full  = (rx_wptr_q[RxAw] != rx_rptr_q[RxAw]) &&
                    (rx_wptr_q[RxAw-1:0] == rx_rptr_q[RxAw-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
    end else begin
      tx_wptr_q <= tx_wptr_q + (TxAw+1)'(tx_push);
      tx_rptr_q <= tx_rptr_q + (TxAw+1)'(tx_pop);
      rx_wptr_q <= rx_wptr_q + (RxAw+1)'(rx_push);
      rx_rptr_q <= rx_rptr_q + (RxAw+1)'(rx_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr_q[TxAw-1:0]] <= tx_wdata;
    if (rx_push) rx_mem[rx_wptr_q[RxAw-1:0]] <= {rx_hi_q, rx_lo_q};
  end

  assign tx_wready = ~tx_full;
  assign rx_rvalid = ~rx_empty;
  assign rx_rdata  = rx_empty ? 8'h00 : rx_mem[rx_rptr_q[RxAw-1:0]];

`ifdef IOEXP_ERR_EN
  logic [1:0] err_q, err_d;

  // Set wins over a coincident clear.
  always_comb begin
    err_d = err_q;
    if (err_clr) err_d = 2'b00;
    err_d = err_d | {rx_ovf_set, tx_unf_set};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 2'b00;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  logic unused_err;
  assign unused_err = ^{err_clr, rx_ovf_set, tx_unf_set};
  assign err        = 2'b00;
`endif

endmodule
